// File: rtl/odd_seq_pkg.sv
// Shared types and constants for the odd-value sequence scheduler.
package odd_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned VAL_W     = 4;
  localparam int unsigned GCNT_W    = 8;
  localparam logic [3:0]  SEQ_FIRST = 4'd1;
  localparam logic [3:0]  SEQ_STEP  = 4'd2;

endpackage

// File: rtl/odd_seq_gen.sv
// Wrapping odd-value generator: 1,3,5,...,MAX_VAL,1,... advancing on step.
module odd_seq_gen
  import odd_seq_pkg::*;
#(
  parameter int unsigned MAX_VAL = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  output logic [VAL_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value <= SEQ_FIRST;
    end else if (step) begin
      value <= (value == VAL_W'(MAX_VAL)) ? SEQ_FIRST : value + SEQ_STEP;
    end
  end

endmodule

// File: rtl/odd_seq_sched.sv
// Two-requester burst scheduler handing out the odd sequence, alternating priority.
// Defining ODD_SEQ_SCHED_STATS_EN adds saturating per-requester grant counters gcnt0/gcnt1.
module odd_seq_sched
  import odd_seq_pkg::*;
#(
  parameter int unsigned BURST_LEN = 2,
  parameter int unsigned MAX_VAL   = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic [VAL_W-1:0]   val_o,
  output logic               val_valid
`ifdef ODD_SEQ_SCHED_STATS_EN
  ,
  output logic [GCNT_W-1:0]  gcnt0,
  output logic [GCNT_W-1:0]  gcnt1
`endif
);

  localparam int unsigned BEAT_W = 2;

  state_t             state;
  state_t             state_nx;
  logic [NUM_REQ-1:0] gnt_nx;
  logic [BEAT_W-1:0]  beat;
  logic [BEAT_W-1:0]  beat_nx;
  logic               ptr;
  logic               ptr_nx;
  logic               owner_c;
  logic               win_c;
  logic               xfer_c;
  logic               end_c;

  // Arbitration, burst tracking and grant termination
  always_comb begin
    state_nx = IDLE;
    gnt_nx   = '0;
    beat_nx  = '0;
    ptr_nx   = ptr;
    owner_c  = gnt[1];
    win_c    = ptr;
    xfer_c   = 1'b0;
    end_c    = 1'b0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          win_c    = (req == 2'b11) ? ptr : req[1];
          state_nx = BUSY;
          gnt_nx   = win_c ? 2'b10 : 2'b01;
        end
      end
      BUSY: begin
        xfer_c = ack[owner_c];
        end_c  = !req[owner_c] || (xfer_c && (beat == BEAT_W'(BURST_LEN - 1)));
        if (end_c) begin
          ptr_nx = !owner_c;
        end else begin
          state_nx = BUSY;
          gnt_nx   = gnt;
          beat_nx  = xfer_c ? beat + BEAT_W'(1) : beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      beat      <= '0;
      ptr       <= 1'b0;
      val_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      beat      <= beat_nx;
      ptr       <= ptr_nx;
      val_valid <= (state_nx == BUSY);
    end
  end

  odd_seq_gen #(
    .MAX_VAL (MAX_VAL)
  ) u_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (xfer_c),
    .value   (val_o)
  );

`ifdef ODD_SEQ_SCHED_STATS_EN
  // Completed grants per requester, sticky at all-ones
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else if (end_c) begin
      if (owner_c) begin
        if (gcnt1 != '1) gcnt1 <= gcnt1 + GCNT_W'(1);
      end else begin
        if (gcnt0 != '1) gcnt0 <= gcnt0 + GCNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/odd_seq_sched.md
ODD_SEQ_SCHED -- requirements
Module: odd_seq_sched

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 2, meaning values delivered per grant (legal 1..4).
REQ-002 The block SHALL have parameter MAX_VAL, default 9, meaning the last odd value before wrap (odd, legal 3..15).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, meaning synchronous active-low reset.
REQ-005 The block SHALL have port req, input, 2, meaning per-requester request for sequence values.
REQ-006 The block SHALL have port ack, input, 2, meaning per-requester acceptance of val_o.
REQ-007 The block SHALL have port gnt, output, 2, meaning registered one-hot grant, or zero.
REQ-008 The block SHALL have port val_o, output, 4, meaning the current odd sequence value.
REQ-009 The block SHALL have port val_valid, output, 1, meaning val_o is offered to the granted requester.

Function
REQ-010 Sequence SHALL be 1,3,5,...,MAX_VAL and then wrap to 1; it advances only on a transfer (val_valid & ack[granted]).
REQ-011 The FSM SHALL have states IDLE and BUSY; any unencoded state SHALL return to IDLE on the next edge.
REQ-012 In IDLE with req!=0, the block SHALL latch the winner and enter BUSY; gnt and val_valid rise the cycle after req is sampled.
REQ-013 Arbitration: one requester -> it wins; both -> requester indicated by priority pointer ptr wins.
REQ-014 In BUSY, gnt SHALL be constant and val_valid=1; ack of the non-granted requester SHALL be ignored.
REQ-015 Each transfer SHALL increment the beat counter; the transfer with beat==BURST_LEN-1 SHALL end the grant.
REQ-016 A grant SHALL also end when req[granted]=0 is sampled in BUSY; a transfer in that same cycle still counts and advances.
REQ-017 Ending a grant SHALL return to IDLE (gnt=0, val_valid=0, beat=0), and set ptr to the other requester.
REQ-018 There SHALL be exactly one IDLE cycle between consecutive grants.
REQ-019 In IDLE, val_o SHALL show the next value to be delivered; val_o SHALL never be even or exceed MAX_VAL.
REQ-020 While val_valid=1 without ack, val_o SHALL hold stable.

Reset
REQ-021 reset_n=0 at an edge SHALL force IDLE, gnt=0, val_valid=0, val_o=1, ptr=requester 0, beat=0, regardless of state.
REQ-022 Reset mid-burst SHALL discard the burst; the first value after reset is 1.

Configuration
REQ-023 With ODD_SEQ_SCHED_STATS_EN defined, the block SHALL add outputs gcnt0 and gcnt1 (8 bits each), counting completed grants per requester, saturating at 255, and cleared by reset.
REQ-024 Without ODD_SEQ_SCHED_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Package odd_seq_pkg SHALL hold the FSM state type, NUM_REQ=2, SEQ_FIRST=4'd1, and the step constant 4'd2.
REQ-026 Sub-module odd_seq_gen (clk, reset_n, step, MAX_VAL -> value) SHALL implement the wrapping odd sequence.
REQ-027 The arbiter, FSM, beat counter, ptr and stats SHALL live in odd_seq_sched.

Verification
REQ-028 Scenario: release reset with req=01 held and ack=01 held; at BURST_LEN=2, req0 gets 1 then 3, gnt drops, there is 1 IDLE cycle, then it is regranted with 5, 7.
REQ-029 Scenario: req=11 from reset, ack always on; grants alternate 0,1,0, delivering values 1,3 / 5,7 / 9,1, which checks the wrap.
REQ-030 Scenario: granted with ack=0 for 5 cycles; val_o holds 1 and val_valid stays 1, and ack[1]=1 has no effect.
REQ-031 Scenario: drop req0 after one transfer; the grant ends and the next grant starts at 3.
REQ-032 Scenario: assert reset_n=0 mid-burst with val_o=5; the next cycle shows IDLE, gnt=0, and val_o=1.
REQ-033 Scenario: with STATS_EN, do 300 grants to req0; gcnt0=255 and gcnt1=0.
